// File: rtl/checkerboard_bist.sv
// Checkerboard BIST initiator for a single-port SRAM: pattern write/read, inverse write/read.
// Optional CKB_STOP_ON_FAIL_EN: abort to DONE on the first mismatch instead of finishing the run.
module checkerboard_bist #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 2,
  parameter int CNT_W  = ADDR_W + 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we_n,
  output logic              mem_cs_n,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              fail_phase,
  output logic [CNT_W-1:0]  fail_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_R0   = 3'd2;
  localparam logic [2:0] S_R0T  = 3'd3;
  localparam logic [2:0] S_W1   = 3'd4;
  localparam logic [2:0] S_R1   = 3'd5;
  localparam logic [2:0] S_R1T  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  // Word for address a in phase ph: base ...0101, inverted on odd checker cells and in phase 1.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic ph);
    logic [DATA_W-1:0] b;
    for (int i = 0; i < DATA_W; i++) b[i] = ((i % 2) == 0);
    return (a[ADDR_W/2] ^ a[0] ^ ph) ? ~b : b;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cs_n_q, cs_n_d, we_n_q, we_n_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic              fail_ph_q, fail_ph_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic              cmp_ph_q, cmp_ph_d;

  logic last, start_ok, rd_now, mismatch, stop;

  always_comb begin
    last     = (addr_q == {ADDR_W{1'b1}});
    start_ok = start && (state_q == S_IDLE || state_q == S_DONE);
    rd_now   = !cs_n_q && we_n_q;
    // Any differing bit, X/Z included, is a mismatch.
    mismatch = cmp_vld_q && (mem_data_out !== exp_q);
`ifdef CKB_STOP_ON_FAIL_EN
    stop     = mismatch;
`else
    stop     = 1'b0;
`endif

    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE, S_DONE: if (start_ok) begin state_d = S_W0; addr_d = '0; end
      S_W0: begin addr_d = addr_q + 1'b1; if (last) state_d = S_R0; end
      S_R0: begin addr_d = addr_q + 1'b1; if (last) state_d = S_R0T; end
      S_R0T: state_d = S_W1;
      S_W1: begin addr_d = addr_q + 1'b1; if (last) state_d = S_R1; end
      S_R1: begin addr_d = addr_q + 1'b1; if (last) state_d = S_R1T; end
      S_R1T: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (stop) begin state_d = S_DONE; addr_d = '0; end

    cs_n_d  = !(state_d == S_W0 || state_d == S_R0 || state_d == S_W1 || state_d == S_R1);
    we_n_d  = !(state_d == S_W0 || state_d == S_W1);
    wdata_d = we_n_d ? '0 : pat(addr_d, state_d == S_W1);
    busy_d  = !(state_d == S_IDLE || state_d == S_DONE);
    done_d  = (state_d == S_DONE);

    // Capture what the read on the bus this cycle should return next cycle.
    cmp_vld_d  = rd_now && !stop;
    exp_d      = pat(addr_q, state_q == S_R1);
    cmp_addr_d = addr_q;
    cmp_ph_d   = (state_q == S_R1);

    fail_cnt_d  = fail_cnt_q;
    fail_addr_d = fail_addr_q;
    fail_ph_d   = fail_ph_q;
    if (start_ok) begin
      fail_cnt_d  = '0;
      fail_addr_d = '0;
      fail_ph_d   = 1'b0;
    end else if (mismatch) begin
      if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_d = fail_cnt_q + 1'b1;
      if (fail_cnt_q == '0) begin
        fail_addr_d = cmp_addr_q;
        fail_ph_d   = cmp_ph_q;
      end
    end
    pass_d = done_d && (fail_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cs_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_ph_q   <= 1'b0;
      fail_cnt_q  <= '0;
      cmp_vld_q   <= 1'b0;
      exp_q       <= '0;
      cmp_addr_q  <= '0;
      cmp_ph_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cs_n_q      <= cs_n_d;
      we_n_q      <= we_n_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_ph_q   <= fail_ph_d;
      fail_cnt_q  <= fail_cnt_d;
      cmp_vld_q   <= cmp_vld_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_ph_q    <= cmp_ph_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_we_n    = we_n_q;
  assign mem_cs_n    = cs_n_q;
  assign mem_data_in = wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign fail_phase  = fail_ph_q;
  assign fail_count  = fail_cnt_q;

endmodule

// File: tb/tb_checkerboard_bist.sv
// Directed bench for checkerboard_bist with a behavioural SRAM that can hold one stuck-at-1 bit.
module tb_checkerboard_bist;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 2;
  localparam int CNT_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_we_n, mem_cs_n;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;
  logic              busy, done, pass, fail_phase;
  logic [ADDR_W-1:0] fail_addr;
  logic [CNT_W-1:0]  fail_count;

  int n_chk = 0;
  int n_fail = 0;
  int cyc;

  logic [DATA_W-1:0] mem [16];
  logic [ADDR_W-1:0] flt_addr = '0;
  logic [DATA_W-1:0] flt_or = '0;

  checkerboard_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_address(mem_address), .mem_we_n(mem_we_n), .mem_cs_n(mem_cs_n),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_phase(fail_phase), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  // SRAM: write on edge, read data registered so it appears the cycle after issue.
  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (!mem_we_n) mem[mem_address] <= mem_data_in;
      else mem_data_out <= mem[mem_address] | ((mem_address == flt_addr) ? flt_or : '0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; start is seen at the next edge (edge 0).
  // cyc counts edges after edge 0; returns with cyc = clocks until done.
  task automatic run(input string nm, input int restart_at, input int rst_at, output int c);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (!done && c < 200) begin
      if (c == 0) begin
        chk({nm, " c0 done"}, 32'(done), 32'd0);
        chk({nm, " c0 busy"}, 32'(busy), 32'd1);
        chk({nm, " c0 fcnt"}, 32'(fail_count), 32'd0);
        chk({nm, " c0 bus"}, {mem_address, mem_cs_n, mem_we_n, mem_data_in}, {28'h0, 4'b0001});
      end
      if (c == 1) chk({nm, " c1 bus"}, {mem_address, mem_cs_n, mem_we_n, mem_data_in}, {28'h1, 4'b0010});
      if (c == 4) chk({nm, " c4 bus"}, {mem_address, mem_cs_n, mem_we_n, mem_data_in}, {28'h4, 4'b0010});
      if (c == 5) chk({nm, " c5 bus"}, {mem_address, mem_cs_n, mem_we_n, mem_data_in}, {28'h5, 4'b0001});
      if (c == 16) chk({nm, " c16 rd0"}, {mem_address, mem_cs_n, mem_we_n}, {28'h0, 2'b01});
      if (c == 32 && restart_at < 0 && rst_at < 0) chk({nm, " r0t csn"}, 32'(mem_cs_n), 32'd1);
      if (c == 33 && restart_at < 0 && rst_at < 0)
        chk({nm, " w1 bus"}, {mem_address, mem_cs_n, mem_we_n, mem_data_in}, {28'h0, 4'b0010});
      start = (c == restart_at);
      if (c == rst_at) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk({nm, " timeout"}, 32'(c < 200), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst csn", 32'(mem_cs_n), 32'd1);
    chk("rst wen", 32'(mem_we_n), 32'd1);
    chk("rst addr/data", {mem_address, mem_data_in}, 32'd0);
    chk("rst flags", {busy, done, pass, fail_phase}, 32'd0);
    chk("rst fail", {fail_addr, fail_count}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle busy", 32'(busy), 32'd0);

    // Fault-free run
    run("ok1", -1, -1, cyc);
    chk("ok1 latency", 32'(cyc), 32'd66);
    chk("ok1 pass", 32'(pass), 32'd1);
    chk("ok1 fcnt", 32'(fail_count), 32'd0);
    chk("ok1 busy", {busy, mem_cs_n}, 32'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("ok1 hold", {done, pass}, 32'b11);

    // Word 5 bit1 stuck-at-1: phase 0 expects 01 and reads 11
    flt_addr = 4'd5; flt_or = 2'b10;
    run("sa1b1", -1, -1, cyc);
`ifdef CKB_STOP_ON_FAIL_EN
    chk("sa1b1 latency", 32'(cyc), 32'd23);
`else
    chk("sa1b1 latency", 32'(cyc), 32'd66);
`endif
    chk("sa1b1 fcnt", 32'(fail_count), 32'd1);
    chk("sa1b1 faddr", 32'(fail_addr), 32'd5);
    chk("sa1b1 fph", 32'(fail_phase), 32'd0);
    chk("sa1b1 pass", {pass, done}, 32'b01);
    chk("sa1b1 csn", 32'(mem_cs_n), 32'd1);

    // Restart from DONE with word 5 bit0 stuck-at-1: phase 1 expects 10 and reads 11
    flt_or = 2'b01;
    run("sa1b0", -1, -1, cyc);
`ifdef CKB_STOP_ON_FAIL_EN
    chk("sa1b0 latency", 32'(cyc), 32'd56);
`else
    chk("sa1b0 latency", 32'(cyc), 32'd66);
`endif
    chk("sa1b0 fcnt", 32'(fail_count), 32'd1);
    chk("sa1b0 faddr", 32'(fail_addr), 32'd5);
    chk("sa1b0 fph", 32'(fail_phase), 32'd1);
    chk("sa1b0 pass", 32'(pass), 32'd0);

    // Start re-pulsed during R0 is ignored
    flt_or = 2'b00;
    run("restart", 20, -1, cyc);
    chk("restart latency", 32'(cyc), 32'd66);
    chk("restart pass", 32'(pass), 32'd1);

    // One-cycle reset during W1
    flt_or = 2'b10;
    run("rstw1", -1, 40, cyc);
    chk("rstw1 csn", 32'(mem_cs_n), 32'd1);
    chk("rstw1 flags", {busy, done, pass}, 32'd0);
    chk("rstw1 fcnt", 32'(fail_count), 32'd0);
    chk("rstw1 addr", 32'(mem_address), 32'd0);
    @(posedge clk); #1;
    chk("rstw1 idle", {busy, done, mem_cs_n}, 32'b001);

    flt_or = 2'b00;
    run("fresh", -1, -1, cyc);
    chk("fresh latency", 32'(cyc), 32'd66);
    chk("fresh pass", {pass, done, busy}, 32'b110);
    chk("fresh fcnt", 32'(fail_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
